sap_datapath: RTL and testbench
===============================

# sap_datapath

SAP-1 datapath that carries out the control word issued by `control_sequencer`. It holds the program counter, MAR, 16x8 RAM, instruction register, accumulator, B register, adder/subtractor and output register, all on an 8-bit W-bus. It returns `op_code` to the sequencer. It also has a programming port for loading RAM before a run.

## Interface
Parameters:
- `RAM_DEPTH`, 16: RAM words; addresses are 4 bits.
- `DATA_W`, 8: bus and register width.

Ports:
- `clk` in 1: single clock; all state updates on the rising edge.
- `res` in 1: reset, synchronous and active-high.
- `inc` in 1: increment PC.
- `pc_out_en` in 1: PC drives bus.
- `low_ld_mar` in 1: active-low MAR load.
- `low_mem_out_en` in 1: active-low, RAM[MAR] drives bus.
- `low_ld_ir` in 1: active-low IR load.
- `low_ir_out_en` in 1: active-low, IR operand drives bus.
- `low_ld_acc` in 1: active-low ACC load.
- `acc_out_en` in 1: ACC drives bus.
- `sub_add` in 1: 1 = subtract, 0 = add.
- `subadd_out_en` in 1: adder result drives bus.
- `low_ld_b_reg` in 1: active-low B load.
- `low_ld_out_reg` in 1: active-low output register load.
- `prog_en` in 1: programming mode; control word is ignored.
- `prog_we` in 1: RAM write strobe, honoured only when `prog_en`=1.
- `prog_addr` in 4: RAM write address.
- `prog_data` in 8: RAM write data.
- `op_code` out 4: IR[7:4].
- `out_reg` out 8: output register.
- `w_bus` out 8: current bus value (debug).
- `pc` out 4: program counter (debug).
- `bus_conflict` out 1: sticky flag for more than one bus driver (see Configuration).

## Operation
Bus is combinational. The enabled source drives it:
- PC: {4'h0, pc}
- RAM: ram[mar]
- IR: {4'h0, ir[3:0]}
- ACC: acc
- Adder: alu
- No source enabled: 8'h00.
- Several sources enabled: priority PC > RAM > IR > ACC > ALU.

ALU is combinational:
- `sub_add`=0: alu = acc + b, modulo 256.
- `sub_add`=1: alu = acc + ~b + 1, modulo 256; borrow is discarded.

Rising edge, when `res`=0 and `prog_en`=0:
- `inc`=1: pc <= pc+1; 4'hF wraps to 4'h0.
- `low_ld_mar`=0: mar <= w_bus[3:0].
- `low_ld_ir`=0: ir <= w_bus.
- `low_ld_acc`=0: acc <= w_bus.
- `low_ld_b_reg`=0: b <= w_bus.
- `low_ld_out_reg`=0: out_reg <= w_bus.

Registers sample the pre-edge bus, so these are legal:
- Several loads in one cycle.
- `inc` together with `pc_out_en`: bus carries the old PC and PC advances.
- `low_ld_acc`=0 together with `subadd_out_en`: ACC takes the old acc ± b.

With `prog_en`=1, every register holds. `prog_we`=1 then writes ram[prog_addr] <= prog_data on the edge.

## Timing
- Reset: `res`=1 at an edge clears pc, mar, ir, acc, b, out_reg and bus_conflict to 0.
  - RAM keeps its contents.
  - A RAM write in that same cycle is suppressed.
  - `res` has priority over `prog_en` and over the control word.
- Reset mid-instruction: the next cycle after reset has `op_code`=0 and `pc`=0.
- Load latency: one edge. The loaded value is visible on outputs after that edge.
- `op_code` changes the cycle after an IR load.
- RAM read is combinational from `mar`. A write becomes readable the cycle after.
- `w_bus` and `alu` have zero latency from control inputs and register state.

## Configuration
- `SAP_BUS_CHECK_EN` defined:
  - On each edge with `res`=0 and `prog_en`=0, `bus_conflict` is set when two or more of `pc_out_en`, !`low_mem_out_en`, !`low_ir_out_en`, `acc_out_en`, `subadd_out_en` are active.
  - The flag stays set until reset.
  - Priority resolution still applies.
- Not defined: `bus_conflict` is tied to 0 and no detection logic is built. Datapath behaviour is otherwise identical.

## Test plan
- Reset: load arbitrary registers, assert `res` for one edge. Then pc, mar, ir, acc, b, out_reg and op_code read 0, and RAM contents are unchanged.
- Program run: load RAM with 0:0x09, 1:0x1A, 2:0x2B, 3:0xE0, 4:0xF0, 9:0x10, A:0x14, B:0x04. Drive the 6-T-state sequencer control words for LDA/ADD/SUB/OUT. Required: `out_reg`=0x20, `op_code`=4'hF after fetch 4, `pc`=5.
- Subtract wrap: acc=0x03, b=0x05, `sub_add`=1 with `subadd_out_en`+`low_ld_acc`=0 → acc=0xFE. Add wrap: acc=0xFF, b=0x02 → 0x01.
- PC: 16 cycles with `inc`=1 from 0 → pc=0. Same-cycle `inc`+`pc_out_en`+`low_ld_mar`=0 at pc=7 → mar=7, pc=8.
- Programming hold: `prog_en`=1 with all loads active, `prog_we`=1, addr 3, data 0x5A → registers unchanged and ram[3]=0x5A. With `res`=1 in the same cycle → ram[3] unchanged.
- Conflict: `pc_out_en`=1 and `acc_out_en`=1 for one cycle → `w_bus` shows PC. With `SAP_BUS_CHECK_EN`, `bus_conflict`=1 and stays 1 until `res`. Without the macro it stays 0.

Source files
------------

// File: rtl/sap_datapath_if.sv
// SAP-1 datapath interface: control word, RAM programming port and
// datapath status outputs. The master side (sequencer / loader) drives the
// control word and programming port; the slave side (datapath) returns
// op_code, out_reg, w_bus, pc and bus_conflict.
interface sap_datapath_if #(
    parameter int DATA_W = 8,
    parameter int ADDR_W = 4
);
    // Control word
    logic                       inc;
    logic                       pc_out_en;
    logic                       low_ld_mar;
    logic                       low_mem_out_en;
    logic                       low_ld_ir;
    logic                       low_ir_out_en;
    logic                       low_ld_acc;
    logic                       acc_out_en;
    logic                       sub_add;
    logic                       subadd_out_en;
    logic                       low_ld_b_reg;
    logic                       low_ld_out_reg;
    // Programming port
    logic                       prog_en;
    logic                       prog_we;
    logic [ADDR_W-1:0]          prog_addr;
    logic [DATA_W-1:0]          prog_data;
    // Status back to the sequencer / debug
    logic [DATA_W-ADDR_W-1:0]   op_code;
    logic [DATA_W-1:0]          out_reg;
    logic [DATA_W-1:0]          w_bus;
    logic [ADDR_W-1:0]          pc;
    logic                       bus_conflict;

    modport master (
        output inc, pc_out_en, low_ld_mar, low_mem_out_en, low_ld_ir,
               low_ir_out_en, low_ld_acc, acc_out_en, sub_add, subadd_out_en,
               low_ld_b_reg, low_ld_out_reg,
               prog_en, prog_we, prog_addr, prog_data,
        input  op_code, out_reg, w_bus, pc, bus_conflict
    );

    modport slave (
        input  inc, pc_out_en, low_ld_mar, low_mem_out_en, low_ld_ir,
               low_ir_out_en, low_ld_acc, acc_out_en, sub_add, subadd_out_en,
               low_ld_b_reg, low_ld_out_reg,
               prog_en, prog_we, prog_addr, prog_data,
        output op_code, out_reg, w_bus, pc, bus_conflict
    );
endinterface

// File: rtl/sap_datapath.sv
// SAP-1 datapath: PC, MAR, 16x8 RAM, IR, ACC, B, adder/subtractor and output
// register around a combinational priority-muxed W-bus.
// Optional feature: define SAP_BUS_CHECK_EN to build the sticky bus_conflict
// detector; otherwise bus_conflict is tied to 0.
module sap_datapath #(
    parameter int RAM_DEPTH = 16,
    parameter int DATA_W    = 8
) (
    input  logic            clk,
    input  logic            res,
    sap_datapath_if.slave   dp
);
    localparam int ADDR_W = $clog2(RAM_DEPTH);
    localparam int PAD_W  = DATA_W - ADDR_W;

    logic [ADDR_W-1:0] pc_reg;
    logic [ADDR_W-1:0] mar_reg;
    logic [DATA_W-1:0] ir_reg;
    logic [DATA_W-1:0] acc_reg;
    logic [DATA_W-1:0] b_reg;
    logic [DATA_W-1:0] outr_reg;
    logic [DATA_W-1:0] ram_mem [RAM_DEPTH];

    logic [DATA_W-1:0] bus_next;
    logic [DATA_W-1:0] alu_next;
    logic [DATA_W-1:0] b_operand;
    logic              run_en;

    // Control word only acts outside reset and programming mode
    assign run_en = !res && !dp.prog_en;

    // Two's-complement subtract: invert B and inject the carry-in
    assign b_operand = dp.sub_add ? ~b_reg : b_reg;
    assign alu_next  = acc_reg + b_operand + {{(DATA_W-1){1'b0}}, dp.sub_add};

    // W-bus source select, fixed priority PC > RAM > IR > ACC > ALU
    always_comb begin
        bus_next = '0;
        if (dp.pc_out_en) begin
            bus_next = {{PAD_W{1'b0}}, pc_reg};
        end else if (!dp.low_mem_out_en) begin
            bus_next = ram_mem[mar_reg];
        end else if (!dp.low_ir_out_en) begin
            bus_next = {{PAD_W{1'b0}}, ir_reg[ADDR_W-1:0]};
        end else if (dp.acc_out_en) begin
            bus_next = acc_reg;
        end else if (dp.subadd_out_en) begin
            bus_next = alu_next;
        end
    end

    // Register file: every register samples the pre-edge bus
    always_ff @(posedge clk) begin
        if (res) begin
            pc_reg   <= '0;
            mar_reg  <= '0;
            ir_reg   <= '0;
            acc_reg  <= '0;
            b_reg    <= '0;
            outr_reg <= '0;
        end else if (run_en) begin
            if (dp.inc)             pc_reg   <= pc_reg + 1'b1;
            if (!dp.low_ld_mar)     mar_reg  <= bus_next[ADDR_W-1:0];
            if (!dp.low_ld_ir)      ir_reg   <= bus_next;
            if (!dp.low_ld_acc)     acc_reg  <= bus_next;
            if (!dp.low_ld_b_reg)   b_reg    <= bus_next;
            if (!dp.low_ld_out_reg) outr_reg <= bus_next;
        end
    end

    // Program RAM: written only from the programming port; reset blocks the write
    always_ff @(posedge clk) begin
        if (!res && dp.prog_en && dp.prog_we) begin
            ram_mem[dp.prog_addr] <= dp.prog_data;
        end
    end

`ifdef SAP_BUS_CHECK_EN
    logic [4:0] src_active;
    logic       multi_src;
    logic       bus_conflict_reg;

    assign src_active = {dp.pc_out_en, !dp.low_mem_out_en, !dp.low_ir_out_en,
                         dp.acc_out_en, dp.subadd_out_en};
    // Clearing the lowest set bit leaves something only if two or more are set
    assign multi_src  = |(src_active & (src_active - 5'd1));

    // Sticky conflict flag, cleared only by reset
    always_ff @(posedge clk) begin
        if (res) begin
            bus_conflict_reg <= 1'b0;
        end else if (run_en && multi_src) begin
            bus_conflict_reg <= 1'b1;
        end
    end

    assign dp.bus_conflict = bus_conflict_reg;
`else
    assign dp.bus_conflict = 1'b0;
`endif

    assign dp.op_code = ir_reg[DATA_W-1:ADDR_W];
    assign dp.out_reg = outr_reg;
    assign dp.w_bus   = bus_next;
    assign dp.pc      = pc_reg;
endmodule

// File: tb/tb_sap_datapath.sv
// Directed testbench for sap_datapath: table-driven SAP-1 program run plus
// hand-written sequences for reset, ALU wrap, PC wrap, programming hold and
// bus conflict.
module tb_sap_datapath;
    logic clk = 1'b0;
    logic res;
    int   n_checks = 0;
    int   n_errors = 0;

    sap_datapath_if dp_if ();

    sap_datapath dut (
        .clk (clk),
        .res (res),
        .dp  (dp_if)
    );

    always #5 clk = ~clk;

    // Control word, MSB first
    typedef struct packed {
        logic inc;
        logic pc_out_en;
        logic low_ld_mar;
        logic low_mem_out_en;
        logic low_ld_ir;
        logic low_ir_out_en;
        logic low_ld_acc;
        logic acc_out_en;
        logic sub_add;
        logic subadd_out_en;
        logic low_ld_b_reg;
        logic low_ld_out_reg;
    } cw_t;

    typedef struct {
        cw_t        cw;
        logic [7:0] exp_bus;
        logic [3:0] exp_op;
        logic [3:0] exp_pc;
    } vec_t;

    localparam cw_t C_NOP       = 12'b0011_1110_0011;
    localparam cw_t C_T1        = 12'b0101_1110_0011; // PC -> MAR
    localparam cw_t C_T2        = 12'b1011_1110_0011; // PC++
    localparam cw_t C_T3        = 12'b0010_0110_0011; // RAM -> IR
    localparam cw_t C_T4_ADDR   = 12'b0001_1010_0011; // IR operand -> MAR
    localparam cw_t C_MEM_ACC   = 12'b0010_1100_0011; // RAM -> ACC
    localparam cw_t C_MEM_B     = 12'b0010_1110_0001; // RAM -> B
    localparam cw_t C_ADD_ACC   = 12'b0011_1100_0111; // ACC+B -> ACC
    localparam cw_t C_SUB_ACC   = 12'b0011_1100_1111; // ACC-B -> ACC
    localparam cw_t C_OUT       = 12'b0011_1111_0010; // ACC -> OUT
    localparam cw_t C_ACC_OUT   = 12'b0011_1111_0011;
    localparam cw_t C_IR_OUT    = 12'b0011_1010_0011;
    localparam cw_t C_MEM_OUT   = 12'b0010_1110_0011;
    localparam cw_t C_ALU_ADD   = 12'b0011_1110_0111;
    localparam cw_t C_MAR_ZERO  = 12'b0001_1110_0011; // idle bus (0) -> MAR
    localparam cw_t C_PC_MAR_I  = 12'b1101_1110_0011;
    localparam cw_t C_ALL_LOADS = 12'b1101_0100_0000;
    localparam cw_t C_CONFLICT  = 12'b0111_1111_0011;

    vec_t vecs[$];

    task automatic add_vec(input cw_t c, input logic [7:0] b, input logic [3:0] o, input logic [3:0] p);
        vec_t v;
        v.cw = c; v.exp_bus = b; v.exp_op = o; v.exp_pc = p;
        vecs.push_back(v);
    endtask

    task automatic check(input string name, input logic [7:0] act, input logic [7:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s: got 0x%02h, expected 0x%02h", name, act, exp);
        end else begin
            $display("ok   %s: 0x%02h", name, act);
        end
    endtask

    task automatic apply_cw(input cw_t c);
        dp_if.inc            = c.inc;
        dp_if.pc_out_en      = c.pc_out_en;
        dp_if.low_ld_mar     = c.low_ld_mar;
        dp_if.low_mem_out_en = c.low_mem_out_en;
        dp_if.low_ld_ir      = c.low_ld_ir;
        dp_if.low_ir_out_en  = c.low_ir_out_en;
        dp_if.low_ld_acc     = c.low_ld_acc;
        dp_if.acc_out_en     = c.acc_out_en;
        dp_if.sub_add        = c.sub_add;
        dp_if.subadd_out_en  = c.subadd_out_en;
        dp_if.low_ld_b_reg   = c.low_ld_b_reg;
        dp_if.low_ld_out_reg = c.low_ld_out_reg;
    endtask

    task automatic run_cw(input cw_t c);
        apply_cw(c);
        @(posedge clk); #1;
        apply_cw(C_NOP);
    endtask

    // Apply a control word without clocking and sample the bus
    task automatic peek(input cw_t c, input string name, input logic [7:0] exp);
        apply_cw(c);
        #2;
        check(name, dp_if.w_bus, exp);
        apply_cw(C_NOP);
    endtask

    task automatic prog_write(input logic [3:0] a, input logic [7:0] d);
        apply_cw(C_NOP);
        dp_if.prog_en = 1'b1; dp_if.prog_we = 1'b1;
        dp_if.prog_addr = a;  dp_if.prog_data = d;
        @(posedge clk); #1;
        dp_if.prog_en = 1'b0; dp_if.prog_we = 1'b0;
    endtask

    task automatic pulse_reset();
        apply_cw(C_NOP);
        res = 1'b1;
        @(posedge clk); #1;
        res = 1'b0;
    endtask

    // Uses ram[0] as a scratch cell: MAR <- 0, IR <- a, MAR <- IR operand
    task automatic set_mar(input logic [3:0] a);
        prog_write(4'h0, {4'h0, a});
        run_cw(C_MAR_ZERO);
        run_cw(C_T3);
        run_cw(C_T4_ADDR);
    endtask

    task automatic load_acc(input logic [7:0] v);
        prog_write(4'h0, v);
        run_cw(C_MAR_ZERO);
        run_cw(C_MEM_ACC);
    endtask

    task automatic load_b(input logic [7:0] v);
        prog_write(4'h0, v);
        run_cw(C_MAR_ZERO);
        run_cw(C_MEM_B);
    endtask

    logic exp_conflict;

    initial begin
`ifdef SAP_BUS_CHECK_EN
        exp_conflict = 1'b1;
`else
        exp_conflict = 1'b0;
`endif
        res = 1'b1;
        apply_cw(C_NOP);
        dp_if.prog_en = 1'b0; dp_if.prog_we = 1'b0;
        dp_if.prog_addr = 4'h0; dp_if.prog_data = 8'h00;
        repeat (2) @(posedge clk);
        #1 res = 1'b0;

        // Reset state
        #2;
        check("reset pc", {4'h0, dp_if.pc}, 8'h00);
        check("reset op_code", {4'h0, dp_if.op_code}, 8'h00);
        check("reset out_reg", dp_if.out_reg, 8'h00);
        check("reset bus idle", dp_if.w_bus, 8'h00);
        check("reset bus_conflict", {7'h0, dp_if.bus_conflict}, 8'h00);

        // Load program: LDA 9, ADD A, SUB B, OUT, HLT
        prog_write(4'h0, 8'h09); prog_write(4'h1, 8'h1A);
        prog_write(4'h2, 8'h2B); prog_write(4'h3, 8'hE0);
        prog_write(4'h4, 8'hF0); prog_write(4'h9, 8'h10);
        prog_write(4'hA, 8'h14); prog_write(4'hB, 8'h04);

        // Six T-states per instruction: bus, op_code and pc seen before each edge
        add_vec(C_T1, 8'h00, 4'h0, 4'h0); add_vec(C_T2, 8'h00, 4'h0, 4'h0);
        add_vec(C_T3, 8'h09, 4'h0, 4'h1); add_vec(C_T4_ADDR, 8'h09, 4'h0, 4'h1);
        add_vec(C_MEM_ACC, 8'h10, 4'h0, 4'h1); add_vec(C_NOP, 8'h00, 4'h0, 4'h1);
        add_vec(C_T1, 8'h01, 4'h0, 4'h1); add_vec(C_T2, 8'h00, 4'h0, 4'h1);
        add_vec(C_T3, 8'h1A, 4'h0, 4'h2); add_vec(C_T4_ADDR, 8'h0A, 4'h1, 4'h2);
        add_vec(C_MEM_B, 8'h14, 4'h1, 4'h2); add_vec(C_ADD_ACC, 8'h24, 4'h1, 4'h2);
        add_vec(C_T1, 8'h02, 4'h1, 4'h2); add_vec(C_T2, 8'h00, 4'h1, 4'h2);
        add_vec(C_T3, 8'h2B, 4'h1, 4'h3); add_vec(C_T4_ADDR, 8'h0B, 4'h2, 4'h3);
        add_vec(C_MEM_B, 8'h04, 4'h2, 4'h3); add_vec(C_SUB_ACC, 8'h20, 4'h2, 4'h3);
        add_vec(C_T1, 8'h03, 4'h2, 4'h3); add_vec(C_T2, 8'h00, 4'h2, 4'h3);
        add_vec(C_T3, 8'hE0, 4'h2, 4'h4); add_vec(C_OUT, 8'h20, 4'hE, 4'h4);
        add_vec(C_NOP, 8'h00, 4'hE, 4'h4); add_vec(C_NOP, 8'h00, 4'hE, 4'h4);
        add_vec(C_T1, 8'h04, 4'hE, 4'h4); add_vec(C_T2, 8'h00, 4'hE, 4'h4);
        add_vec(C_T3, 8'hF0, 4'hE, 4'h5);

        for (int i = 0; i < vecs.size(); i++) begin
            apply_cw(vecs[i].cw);
            @(negedge clk);
            check($sformatf("run[%0d] w_bus", i), dp_if.w_bus, vecs[i].exp_bus);
            check($sformatf("run[%0d] op_code", i), {4'h0, dp_if.op_code}, {4'h0, vecs[i].exp_op});
            check($sformatf("run[%0d] pc", i), {4'h0, dp_if.pc}, {4'h0, vecs[i].exp_pc});
            @(posedge clk); #1;
        end
        apply_cw(C_NOP);
        #2;
        check("run out_reg", dp_if.out_reg, 8'h20);
        check("run op_code HLT", {4'h0, dp_if.op_code}, 8'h0F);
        check("run pc", {4'h0, dp_if.pc}, 8'h05);
        check("run no conflict", {7'h0, dp_if.bus_conflict}, 8'h00);

        // Reset beats control word and programming write
        apply_cw(C_T1);
        res = 1'b1;
        dp_if.prog_en = 1'b1; dp_if.prog_we = 1'b1;
        dp_if.prog_addr = 4'h9; dp_if.prog_data = 8'h77;
        @(posedge clk); #1;
        res = 1'b0; dp_if.prog_en = 1'b0; dp_if.prog_we = 1'b0;
        apply_cw(C_NOP);
        #2;
        check("rst pc", {4'h0, dp_if.pc}, 8'h00);
        check("rst op_code", {4'h0, dp_if.op_code}, 8'h00);
        check("rst out_reg", dp_if.out_reg, 8'h00);
        peek(C_ACC_OUT, "rst acc", 8'h00);
        peek(C_IR_OUT, "rst ir operand", 8'h00);
        peek(C_ALU_ADD, "rst acc+b", 8'h00);
        peek(C_MEM_OUT, "rst mar=0 ram kept", 8'h09);
        set_mar(4'h9);
        peek(C_MEM_OUT, "rst ram[9] write suppressed", 8'h10);

        // Subtract wrap: 0x03 - 0x05
        load_acc(8'h03);
        load_b(8'h05);
        apply_cw(C_SUB_ACC);
        #2 check("alu sub wrap bus", dp_if.w_bus, 8'hFE);
        @(posedge clk); #1;
        peek(C_ACC_OUT, "acc after sub wrap", 8'hFE);

        // Add wrap: 0xFF + 0x02
        load_acc(8'hFF);
        load_b(8'h02);
        apply_cw(C_ADD_ACC);
        #2 check("alu add wrap bus", dp_if.w_bus, 8'h01);
        @(posedge clk); #1;
        peek(C_ACC_OUT, "acc after add wrap", 8'h01);

        // PC wrap after 16 increments
        pulse_reset();
        run_cw(C_T2);
        #2 check("pc after 1 inc", {4'h0, dp_if.pc}, 8'h01);
        repeat (15) run_cw(C_T2);
        #2 check("pc wrap 16 incs", {4'h0, dp_if.pc}, 8'h00);

        // Same-cycle inc + PC out + MAR load
        prog_write(4'h7, 8'hA7);
        repeat (7) run_cw(C_T2);
        apply_cw(C_PC_MAR_I);
        #2 check("inc+pc_out bus", dp_if.w_bus, 8'h07);
        @(posedge clk); #1;
        apply_cw(C_NOP);
        #2 check("inc+pc_out pc", {4'h0, dp_if.pc}, 8'h08);
        peek(C_MEM_OUT, "inc+pc_out mar", 8'hA7);

        // Programming mode holds every register while writing RAM
        load_acc(8'h33);
        apply_cw(C_ALL_LOADS);
        dp_if.prog_en = 1'b1; dp_if.prog_we = 1'b1;
        dp_if.prog_addr = 4'h3; dp_if.prog_data = 8'h5A;
        @(posedge clk); #1;
        dp_if.prog_en = 1'b0; dp_if.prog_we = 1'b0;
        apply_cw(C_NOP);
        #2;
        check("hold pc", {4'h0, dp_if.pc}, 8'h08);
        check("hold out_reg", dp_if.out_reg, 8'h00);
        peek(C_ACC_OUT, "hold acc", 8'h33);
        peek(C_ALU_ADD, "hold b", 8'h33);
        peek(C_MEM_OUT, "hold mar", 8'h33);
        set_mar(4'h3);
        peek(C_MEM_OUT, "prog ram[3]", 8'h5A);

        // Programming write during reset is dropped
        apply_cw(C_NOP);
        res = 1'b1;
        dp_if.prog_en = 1'b1; dp_if.prog_we = 1'b1;
        dp_if.prog_addr = 4'h3; dp_if.prog_data = 8'hC3;
        @(posedge clk); #1;
        res = 1'b0; dp_if.prog_en = 1'b0; dp_if.prog_we = 1'b0;
        set_mar(4'h3);
        peek(C_MEM_OUT, "rst+prog ram[3] kept", 8'h5A);

        // Bus conflict: PC and ACC both enabled
        load_acc(8'h66);
        #2 check("pre-conflict flag", {7'h0, dp_if.bus_conflict}, 8'h00);
        apply_cw(C_CONFLICT);
        #2 check("conflict bus = pc", dp_if.w_bus, 8'h00);
        @(posedge clk); #1;
        apply_cw(C_NOP);
        #2 check("conflict flag", {7'h0, dp_if.bus_conflict}, {7'h0, exp_conflict});
        repeat (3) run_cw(C_NOP);
        #2 check("conflict flag sticky", {7'h0, dp_if.bus_conflict}, {7'h0, exp_conflict});
        pulse_reset();
        #2 check("conflict flag cleared", {7'h0, dp_if.bus_conflict}, 8'h00);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

    // Hard time limit so the run always ends
    initial begin
        #200000;
        $display("FAIL timeout: simulation did not finish, expected completion");
        $fatal(1, "timeout");
    end
endmodule
